apu_note_sequencer: RTL and testbench
=====================================

# apu_note_sequencer

Plays a fixed tune on the audio processing unit without a CPU. It fetches 16-bit event words from a synchronous pattern ROM and issues per-channel note writes to the APU register port through a valid/ready handshake. It paces playback by counting the APU frame pulse (`o_frame_pulse[0]`). It sits between the pattern ROM and the APU, in the same top level as the switch debouncer and the PWM output stage.

## Interface
- `ADDR_WIDTH`, default 8: pattern ROM address width; address wraps modulo 2^ADDR_WIDTH.
- `START_ADDR`, default 0: address of the first event fetched after `i_start`.

- `i_clk`, input, 1: system clock; the only clock.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_start`, input, 1: one-cycle pulse that starts playback from `START_ADDR`. Honoured only in IDLE or DONE.
- `i_stop`, input, 1: one-cycle pulse that aborts playback and returns the block to IDLE.
- `i_frame_pulse`, input, 1: one-cycle tick, once per APU frame.
- `o_rom_addr`, output, ADDR_WIDTH: registered ROM address.
- `i_rom_data`, input, 16: ROM word for `o_rom_addr`, valid one cycle after the address is presented.
- `o_wr_valid`, output, 1: a note write is pending.
- `o_wr_channel`, output, 2: target APU channel.
- `o_wr_note`, output, 6: note-table index.
- `i_wr_ready`, input, 1: APU accepts the write.
- `o_busy`, output, 1: high in every state except IDLE and DONE.
- `o_done`, output, 1: high in the DONE state.

## Operation
Event word format, with `op` = `[15:14]`:
- `00` NOTE: channel `[13:12]`, note `[11:6]`, duration `[5:0]` in frames.
- `01` WAIT: duration `[5:0]` in frames; no write.
- `10` JUMP: target `[ADDR_WIDTH-1:0]`.
- `11` END.

States:
- IDLE: waits for `i_start`. On start: `o_rom_addr <= START_ADDR`, go to FETCH.
- FETCH: one cycle while the address is presented. Go to DECODE.
- DECODE: samples `i_rom_data`.
  - NOTE: load `o_wr_*`, assert `o_wr_valid`, go to WRITE.
  - WAIT: load the counter and go to DELAY if the duration is nonzero. If zero, advance the address and go to FETCH.
  - JUMP: `o_rom_addr <= target`, go to FETCH.
  - END: go to DONE.
- WRITE: hold `o_wr_valid`, `o_wr_channel` and `o_wr_note` stable until the cycle where `o_wr_valid && i_wr_ready`. In that cycle, deassert valid and advance the address (+1, wrapping). Then go to DELAY if the duration is nonzero, else go to FETCH (duration 0 lets events stack into chords).
- DELAY: a 6-bit counter decrements on each `i_frame_pulse`. When a pulse arrives with counter == 1, go to FETCH. A pulse in the same cycle as the DECODE/WRITE exit that enters DELAY is not counted.
- DONE: holds until `i_start` (restart) or `i_stop` (go to IDLE).

Stop rules:
- `i_stop` in FETCH, DECODE or DELAY: go to IDLE next cycle.
- `i_stop` in WRITE: latched and deferred until the handshake completes, so valid never drops before it is accepted; then go to IDLE.
- `i_stop` and `i_start` in the same cycle: stop wins.

Other rules:
- `i_start` while busy is ignored.
- A JUMP to itself loops forever by design; `i_stop` breaks it.

## Timing
- Reset: state IDLE. `o_rom_addr`=0, `o_wr_valid`=0, `o_wr_channel`=0, `o_wr_note`=0, `o_busy`=0, `o_done`=0, counter=0, stop latch cleared. Reset mid-write drops `o_wr_valid` next cycle; this is the only case where valid drops without acceptance.
- All outputs are registered.
- Start to first `o_wr_valid`: `i_start` at cycle T; FETCH at T+1; DECODE at T+2; `o_wr_valid` high at T+3.
- Back-to-back NOTE events with duration 0 and ready tied high: one write every 3 cycles.
- NOTE with duration N: next FETCH in the cycle after the N-th counted frame pulse.
- Address wrap: an event at 2^ADDR_WIDTH−1 advances to 0.

## Test plan
- Reset, then idle 10 cycles: all outputs 0. `i_start` at T gives `o_rom_addr`=0 at T+1 and `o_wr_valid` at T+3.
- ROM[0]=NOTE ch2 note 17 dur 3, ROM[1]=END, `i_wr_ready` held low 5 cycles: valid, channel=2, note=17 stay stable until ready. After exactly 3 frame pulses, `o_done`=1 and `o_busy`=0.
- ROM[0..2]=NOTE dur 0 on ch0, ch1, ch2, ROM[3]=END, ready tied 1: three writes, 3 cycles apart, then DONE.
- ROM[5]=JUMP 2 with ADDR_WIDTH=8, and a separate event at 255 (WAIT 1): after the JUMP, fetch from address 2; after address 255, fetch from address 0.
- `i_stop` while in WRITE with ready low 4 cycles: write is still accepted, then IDLE with `o_busy`=0. `i_stop` in DELAY: IDLE next cycle.
- Frame pulse coincident with WRITE acceptance for a dur-1 NOTE: not counted; the next pulse ends DELAY. `i_start` during DELAY: ignored, address unchanged.

Source files
------------

// File: rtl/apu_note_sequencer.sv
// apu_note_sequencer: plays a pattern ROM tune as APU note writes paced by frame pulses
module apu_note_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_frame_pulse,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [15:0]           i_rom_data,
  output logic                  o_wr_valid,
  output logic [1:0]            o_wr_channel,
  output logic [5:0]            o_wr_note,
  input  logic                  i_wr_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, WRITE, DELAY, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0] ch_q;
  logic [5:0] note_q, dur_q, cnt_q;
  logic valid_q, busy_q, done_q, stop_q;
  wire [1:0] op = i_rom_data[15:14];
  wire [5:0] dur_in = i_rom_data[5:0];
  wire accept = valid_q && i_wr_ready;
  wire [ADDR_WIDTH-1:0] addr_inc = ADDR_WIDTH'(addr_q + 1'b1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = (i_start && !i_stop) ? FETCH : IDLE;
      FETCH:  state_d = i_stop ? IDLE : DECODE;
      DECODE: state_d = i_stop ? IDLE :
                        op == 2'b00 ? WRITE :
                        op == 2'b01 ? (dur_in != 6'd0 ? DELAY : FETCH) :
                        op == 2'b10 ? FETCH : DONE;
      // a stop seen during the handshake waits for acceptance
      WRITE:  state_d = !accept ? WRITE :
                        (stop_q || i_stop) ? IDLE :
                        dur_q != 6'd0 ? DELAY : FETCH;
      DELAY:  state_d = i_stop ? IDLE : (i_frame_pulse && cnt_q == 6'd1) ? FETCH : DELAY;
      DONE:   state_d = i_stop ? IDLE : i_start ? FETCH : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= 2'd0;
      note_q  <= 6'd0;
      dur_q   <= 6'd0;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= !(state_d == IDLE || state_d == DONE);
      done_q  <= state_d == DONE;
      stop_q  <= state_q == WRITE && state_d == WRITE && (stop_q || i_stop);
      case (state_q)
        IDLE, DONE: if (state_d == FETCH) addr_q <= START_ADDR;
        DECODE: if (!i_stop) begin
          case (op)
            2'b00: begin
              valid_q <= 1'b1;
              ch_q    <= i_rom_data[13:12];
              note_q  <= i_rom_data[11:6];
              dur_q   <= dur_in;
            end
            2'b01: begin
              cnt_q  <= dur_in;
              addr_q <= addr_inc;
            end
            2'b10: addr_q <= i_rom_data[ADDR_WIDTH-1:0];
            default: ;
          endcase
        end
        WRITE: if (accept) begin
          valid_q <= 1'b0;
          addr_q  <= addr_inc;
          cnt_q   <= dur_q;
        end
        DELAY: if (i_frame_pulse && !i_stop) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
  assign o_rom_addr   = addr_q;
  assign o_wr_valid   = valid_q;
  assign o_wr_channel = ch_q;
  assign o_wr_note    = note_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
endmodule

// File: tb/tb_apu_note_sequencer.sv
// tb_apu_note_sequencer: directed stimulus with a write scoreboard and a handshake monitor
module tb_apu_note_sequencer;
  logic clk = 1'b0;
  logic rst, start, stop, frame, ready;
  logic [7:0] addr;
  logic [15:0] rom_data;
  logic valid, busy, done;
  logic [1:0] ch;
  logic [5:0] note;
  logic [15:0] rom [256];
  int total = 0, passed = 0, cyc_n = 0;
  logic [7:0] exp_q[$];
  int acc_t[$];
  logic [7:0] addr_log[$];
  logic rec_acc = 1'b0, rec_addr = 1'b0, hold_p = 1'b0;
  logic [7:0] hold_v, last_addr;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[addr];
  always @(posedge clk) cyc_n <= cyc_n + 1;

  apu_note_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_frame_pulse(frame),
    .o_rom_addr(addr), .i_rom_data(rom_data), .o_wr_valid(valid), .o_wr_channel(ch),
    .o_wr_note(note), .i_wr_ready(ready), .o_busy(busy), .o_done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] nw(input logic [1:0] c, input logic [5:0] n, input logic [5:0] d);
    return {2'b00, c, n, d};
  endfunction

  always @(negedge clk) begin
    if (rst) hold_p = 1'b0;
    else begin
      if (hold_p) check("hold_stable", {valid, ch, note}, {1'b1, hold_v});
      if (valid && ready) begin
        if (exp_q.size() == 0) check("write_expected", 0, 1);
        else check("write_data", {ch, note}, exp_q.pop_front());
        if (rec_acc) acc_t.push_back(cyc_n);
      end
      hold_p = valid && !ready;
      hold_v = {ch, note};
      if (rec_addr && addr != last_addr) addr_log.push_back(addr);
      last_addr = addr;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1; cyc(); frame = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 20) begin cyc(); n++; end
    check(name, valid, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin cyc(); n++; end
    check(name, {done, busy}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    rst = 1'b1; start = 1'b0; stop = 1'b0; frame = 1'b0; ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(10);
    check("reset_outputs", {addr, valid, ch, note, busy, done}, 0);

    // held-off write, duration 3
    rom[0] = nw(2'd2, 6'd17, 6'd3);
    rom[1] = 16'hC000;
    exp_q.push_back({2'd2, 6'd17});
    pulse_start();
    check("fetch_at_t1", {busy, addr}, {1'b1, 8'd0});
    cyc();
    check("no_valid_at_t2", valid, 0);
    cyc();
    check("valid_at_t3", {valid, ch, note}, {1'b1, 2'd2, 6'd17});
    cyc(5);
    ready = 1'b1; cyc(); ready = 1'b0;
    check("valid_dropped", valid, 0);
    pulse_frame(); cyc(2);
    pulse_frame(); cyc(5);
    check("not_done_after_2", {done, busy}, 2'b01);
    pulse_frame(); cyc(3);
    check("done_after_3", {done, busy}, 2'b10);

    // chord: three dur-0 notes, ready tied high
    rom[0] = nw(2'd0, 6'd5, 6'd0);
    rom[1] = nw(2'd1, 6'd6, 6'd0);
    rom[2] = nw(2'd2, 6'd7, 6'd0);
    rom[3] = 16'hC000;
    exp_q.push_back({2'd0, 6'd5});
    exp_q.push_back({2'd1, 6'd6});
    exp_q.push_back({2'd2, 6'd7});
    ready = 1'b1; rec_acc = 1'b1;
    pulse_start();
    wait_done("chord_done");
    rec_acc = 1'b0;
    check("chord_count", acc_t.size(), 3);
    if (acc_t.size() == 3) begin
      check("chord_gap1", acc_t[1] - acc_t[0], 3);
      check("chord_gap2", acc_t[2] - acc_t[1], 3);
    end

    // jumps and address wrap
    rom[0] = 16'h8005;
    rom[5] = 16'h8002;
    rom[2] = 16'h80FF;
    rom[255] = 16'h4001;
    last_addr = addr; rec_addr = 1'b1;
    pulse_start();
    for (int n = 0; n < 30 && addr != 8'hFF; n++) cyc();
    check("reached_255", addr, 8'hFF);
    rom[0] = nw(2'd3, 6'd33, 6'd0);
    rom[1] = 16'hC000;
    exp_q.push_back({2'd3, 6'd33});
    cyc(3);
    pulse_frame();
    wait_done("jump_done");
    rec_addr = 1'b0;
    check("addr_log_len", addr_log.size(), 6);
    if (addr_log.size() == 6)
      check("addr_seq", {addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[4], addr_log[5]},
            {8'd0, 8'd5, 8'd2, 8'd255, 8'd0, 8'd1});

    // stop during a held-off write
    rom[0] = nw(2'd1, 6'd40, 6'd2);
    rom[1] = 16'hC000;
    exp_q.push_back({2'd1, 6'd40});
    ready = 1'b0;
    pulse_start();
    wait_valid("stop_write_valid");
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc(3);
    check("valid_held_after_stop", {valid, busy}, 2'b11);
    ready = 1'b1; cyc(); ready = 1'b0;
    check("idle_after_stop", {busy, valid, done}, 0);

    // stop during delay
    rom[0] = nw(2'd0, 6'd1, 6'd5);
    exp_q.push_back({2'd0, 6'd1});
    ready = 1'b1;
    pulse_start();
    cyc(5);
    check("in_delay", {busy, valid}, 2'b10);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("idle_after_delay_stop", {busy, done}, 0);

    // frame pulse at acceptance not counted; start ignored while busy
    rom[0] = nw(2'd2, 6'd50, 6'd1);
    exp_q.push_back({2'd2, 6'd50});
    ready = 1'b0;
    pulse_start();
    wait_valid("coinc_valid");
    ready = 1'b1; frame = 1'b1; cyc(); ready = 1'b0; frame = 1'b0;
    cyc(3);
    check("pulse_at_accept_ignored", {busy, done, addr}, {2'b10, 8'd1});
    pulse_start();
    cyc();
    check("start_ignored_in_delay", {busy, addr}, {1'b1, 8'd1});
    pulse_frame();
    wait_done("coinc_done");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
